// File: rtl/preif_fetch_unit.sv
// Pre-IF fetch address generator: redirect arbitration, SRAM request issue,
// outstanding/discard tracking. Optional MMU hookup under PREIF_TLB_EX_EN.
module preif_fetch_unit #(
    parameter int          NUM_REDIR   = 4,
    parameter int          FETCH_BYTES = 4,
    parameter int          MAX_OUTST   = 2,
    parameter logic [31:0] RESET_PC    = 32'h1c000000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REDIR-1:0]   redir_valid,
    input  logic [32*NUM_REDIR-1:0] redir_target,
    input  logic                   if_allowin,
    output logic                   inst_sram_req,
    output logic [31:0]            inst_sram_addr,
    output logic [1:0]             inst_sram_size,
    input  logic                   inst_sram_addr_ok,
    input  logic                   inst_sram_data_ok,
    output logic                   to_if_valid,
    output logic [31:0]            to_if_pc,
    output logic                   to_if_ex,
    output logic [5:0]             to_if_ecode,
    output logic                   resp_discard
`ifdef PREIF_TLB_EX_EN
    ,
    output logic [31:0]            mmu_vaddr,
    input  logic [31:0]            mmu_paddr,
    input  logic                   mmu_ex_tlbr,
    input  logic                   mmu_ex_pif,
    input  logic                   mmu_ex_ppi
`endif
);

    localparam int          IDX_W      = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
    localparam logic [31:0] ALIGN_MASK = 32'(FETCH_BYTES - 1);
    localparam logic [1:0]  SIZE_ENC   = 2'($clog2(FETCH_BYTES));
    localparam logic [2:0]  OUTST_MAX  = 3'(MAX_OUTST);
    localparam logic [5:0]  EC_ADEF    = 6'h08;

    logic [31:0]      pc_r;
    logic             pend_v;
    logic [IDX_W-1:0] pend_idx;
    logic [31:0]      pend_tgt;
    logic [2:0]       outst;
    logic [2:0]       discard;
    logic             halt;

    logic             win_v;
    logic [IDX_W-1:0] win_idx;
    logic [31:0]      win_tgt;
    logic             take_win;
    logic [31:0]      seq_pc;
    logic [31:0]      next_pc;
    logic [31:0]      phys_addr;
    logic             adef;
    logic             fault;
    logic [5:0]       fault_code;
    logic             can_issue;
    logic             slot_free;
    logic             ex_go;
    logic             accept;
    logic             advance;
    logic             rsp;

    // Descending scan so the lowest asserted index is the last one written.
    always_comb begin
        win_v   = 1'b0;
        win_idx = '0;
        win_tgt = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                win_v   = 1'b1;
                win_idx = IDX_W'(i);
                win_tgt = redir_target[32*i +: 32];
            end
        end
    end

    assign take_win = win_v && (!pend_v || (win_idx < pend_idx));
    assign seq_pc   = (pc_r & ~ALIGN_MASK) + 32'(FETCH_BYTES);
    assign next_pc  = take_win ? win_tgt : (pend_v ? pend_tgt : seq_pc);
    assign adef     = (next_pc[1:0] != 2'b00);

`ifdef PREIF_TLB_EX_EN
    assign mmu_vaddr = next_pc;
    assign phys_addr = mmu_paddr;
    assign fault     = adef || mmu_ex_tlbr || mmu_ex_pif || mmu_ex_ppi;
    assign fault_code = adef        ? EC_ADEF :
                        mmu_ex_tlbr ? 6'h3F   :
                        mmu_ex_pif  ? 6'h03   : 6'h07;
`else
    assign phys_addr  = next_pc;
    assign fault      = adef;
    assign fault_code = EC_ADEF;
`endif

    assign can_issue      = if_allowin && !halt;
    assign slot_free      = (outst < OUTST_MAX) || inst_sram_data_ok;
    assign inst_sram_req  = can_issue && slot_free && !fault;
    assign inst_sram_addr = inst_sram_req ? (phys_addr & ~ALIGN_MASK) : '0;
    assign inst_sram_size = inst_sram_req ? SIZE_ENC : 2'b00;
    assign ex_go          = can_issue && fault;
    assign accept         = inst_sram_req && inst_sram_addr_ok;
    assign advance        = accept || ex_go;
    assign rsp            = inst_sram_data_ok && (outst != 3'd0);
    assign resp_discard   = inst_sram_data_ok && (discard != 3'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_r        <= RESET_PC - 32'(FETCH_BYTES);
            pend_v      <= 1'b0;
            pend_idx    <= '0;
            pend_tgt    <= '0;
            outst       <= 3'd0;
            discard     <= 3'd0;
            halt        <= 1'b1;
            to_if_valid <= 1'b0;
            to_if_pc    <= '0;
            to_if_ex    <= 1'b0;
            to_if_ecode <= '0;
        end else begin
            halt <= 1'b0;
            // An advance consumes whatever was selected; a losing same-cycle redirect re-arms the latch.
            if (advance) begin
                pc_r     <= next_pc;
                pend_v   <= win_v && !take_win;
                pend_idx <= win_idx;
                pend_tgt <= win_tgt;
            end else if (take_win) begin
                pend_v   <= 1'b1;
                pend_idx <= win_idx;
                pend_tgt <= win_tgt;
            end
            outst <= outst + {2'b00, accept} - {2'b00, rsp};
            if (|redir_valid) begin
                discard <= outst - {2'b00, rsp};
            end else if (resp_discard) begin
                discard <= discard - 3'd1;
            end
            to_if_valid <= advance;
            to_if_pc    <= advance ? next_pc : '0;
            to_if_ex    <= ex_go;
            to_if_ecode <= ex_go ? fault_code : '0;
        end
    end

endmodule
